// File: rtl/multiplier_pkg.sv
// Shared constants and types for the sequential shift-and-add multiplier.
package multiplier_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } operands_t;

endpackage

// File: rtl/multiplier_if.sv
// Operand/handshake bundle between a requester (master) and the multiplier (slave).
interface multiplier_if;
    import multiplier_pkg::*;

    logic [WIDTH-1:0]  A_i;
    logic [WIDTH-1:0]  B_i;
    logic              start_i;
    logic [PROD_W-1:0] result_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output A_i, B_i, start_i,
        input  result_o, busy_o, done_o
    );

    modport slave (
        input  A_i, B_i, start_i,
        output result_o, busy_o, done_o
    );

endinterface

// File: rtl/multiplier_datapath.sv
// Shift-and-add registers: shifted multiplicand, shifting multiplier and accumulator.
module multiplier_datapath
    import multiplier_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  operands_t         ops_i,
    output logic [PROD_W-1:0] acc_o
);

    logic [PROD_W-1:0] mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PROD_W-1:0] acc_q;

    // Load takes priority; each step consumes one multiplier bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= PROD_W'(ops_i.a);
            mplier_q <= ops_i.b;
            acc_q    <= '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier with start/busy/done handshake.
module multiplier
    import multiplier_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    multiplier_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_c;
    logic              step_c;
    logic [PROD_W-1:0] acc_c;
    operands_t         ops_c;

    assign ops_c.a = bus.A_i;
    assign ops_c.b = bus.B_i;

    multiplier_datapath u_datapath (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load_c),
        .step_i (step_c),
        .ops_i  (ops_c),
        .acc_o  (acc_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Fixed WIDTH-cycle CALC phase; done is a one-cycle pulse issued from DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_c   = 1'b0;
        step_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_d = acc_c;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the sequential multiplier.
module tb_multiplier;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multiplier_if bus();

    multiplier dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy window, done pulse and held result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag, input bit disturb);
        int lat;
        bit busy_drop;
        @(negedge clk);
        bus.A_i     = a;
        bus.B_i     = b;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_accept"}, 64'(bus.busy_o), 64'd1);
        bus.start_i = 1'b0;
        lat       = 0;
        busy_drop = 1'b0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (disturb) begin
                bus.start_i = (lat == 5 || lat == 32);
                bus.A_i     = ~a;
                bus.B_i     = b + 32'd77;
            end
            if (bus.done_o) break;
            if (!bus.busy_o) busy_drop = 1'b1;
        end
        bus.start_i = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_window"}, 64'(busy_drop), 64'd0);
        check({tag, "_result"}, bus.result_o, exp);
        check({tag, "_busy_at_done"}, 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
        check({tag, "_result_hold"}, bus.result_o, exp);
    endtask

    initial begin
        int extra_done;
        logic [31:0] ra, rb;
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        bus.A_i     = '0;
        bus.B_i     = '0;
        bus.start_i = 1'b0;

        // Asynchronous reset asserted mid-cycle
        #7 rst = 1'b1;
        #1;
        check("rst_result", bus.result_o, 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_result", bus.result_o, 64'd0);
        check("idle_busy", 64'(bus.busy_o), 64'd0);
        check("idle_done", 64'(bus.done_o), 64'd0);

        do_op(32'd3, 32'd5, 64'd15, "basic", 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "ones", 1'b0);
        do_op(32'd0, 32'h1234_5678, 64'd0, "zero", 1'b0);
        do_op(32'd7, 32'd6, 64'd42, "stable", 1'b1);

        // No further done pulse after the disturbed operation
        extra_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done_o) extra_done++;
        end
        check("stable_single_done", 64'(extra_done), 64'd0);
        check("stable_idle_busy", 64'(bus.busy_o), 64'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.A_i     = 32'd100;
        bus.B_i     = 32'd200;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_result", bus.result_o, 64'd0);
        check("midrst_busy", 64'(bus.busy_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.done_o) extra_done++;
        end
        check("midrst_no_done", 64'(extra_done), 64'd0);
        check("midrst_result_after", bus.result_o, 64'd0);
        do_op(32'd2, 32'd9, 64'd18, "after_rst", 1'b0);

        // Back-to-back random operands against a 64-bit reference product
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(ra, rb, 64'(ra) * 64'(rb), $sformatf("rand%0d", i), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH operands in, 2*WIDTH-bit product out.
- Start/busy/done handshake; one multiplier bit processed per clock.
- Used as a low-area arithmetic unit wherever a multi-cycle product is acceptable.

Parameters:
- WIDTH, 32, operand width in bits; result width is 2*WIDTH. Defined in multiplier_pkg and imported by the module.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- A_i  input  WIDTH  multiplicand, unsigned
- B_i  input  WIDTH  multiplier, unsigned
- start_i  input  1  request; sampled on rising clk_i only while idle
- result_o  output  2*WIDTH  product A_i*B_i of the last accepted operation
- busy_o  output  1  high while an operation is in progress
- done_o  output  1  single-cycle completion pulse

Behaviour:
- Reset (rst_i=1, asynchronous): state=IDLE; result_o=0, busy_o=0, done_o=0; internal accumulator, counter and operand registers cleared.
- Reset mid-operation aborts the operation; no done_o pulse follows; result_o returns to 0.
- States: IDLE, CALC, DONE.
- IDLE: when start_i=1 at a rising edge:
  - latch A_i zero-extended to 2*WIDTH as the shifted multiplicand;
  - latch B_i as the shifting multiplier;
  - clear the 2*WIDTH accumulator and the bit counter;
  - busy_o<=1; go to CALC.
- Operands are captured only at the accepting edge; later changes on A_i/B_i have no effect.
- CALC, each cycle:
  - if multiplier LSB=1, accumulator += multiplicand, computed 2*WIDTH wide with no overflow possible;
  - multiplicand <<= 1, multiplier >>= 1, counter++;
  - after exactly WIDTH CALC cycles go to DONE.
- DONE (one cycle):
  - result_o<=accumulator, done_o<=1, busy_o<=0;
  - next edge: done_o<=0, go to IDLE.
- Latency: start_i sampled at edge N. busy_o is high from edge N to edge N+WIDTH+1. done_o and the valid result_o appear at edge N+WIDTH+1; done_o lasts exactly one cycle.
- result_o holds its value after done_o falls, until the next completion or reset. It is not cleared when a new operation starts.
- start_i while busy (CALC or DONE) is ignored, with no queuing. A start_i held high continuously restarts only from IDLE, i.e. the next operation begins the cycle after done_o.
- All outputs are driven from registers; no combinational path from inputs to outputs.
- Operands 0 and all-ones need no special handling; the latency stays fixed at WIDTH+1 cycles after acceptance, with no early termination.

Decomposition:
- multiplier_pkg: WIDTH constant, the state enum type (IDLE/CALC/DONE), and the counter width constant $clog2(WIDTH+1).
- Single module. An optional sub-module multiplier_datapath holds the accumulator/shift registers, with the FSM in the top module. A flat implementation is acceptable.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> result_o=0, busy_o=0, done_o=0 immediately. Release, then idle with start_i=0 -> outputs stay 0.
- Basic: A_i=3, B_i=5, one-cycle start_i pulse -> busy_o high for WIDTH+1 cycles; done_o one-cycle pulse exactly WIDTH+1 edges after acceptance; result_o=15 and held afterwards.
- Extremes:
  - A_i=32'hFFFF_FFFF, B_i=32'hFFFF_FFFF -> result_o=64'hFFFF_FFFE_0000_0001;
  - A_i=0, B_i=32'h1234_5678 -> result_o=0 with the same latency.
- Operand stability and ignored start: change A_i/B_i and pulse start_i during busy (A_i=7, B_i=6 accepted) -> result_o=42; only one done_o pulse.
- Mid-operation reset: start A_i=100, B_i=200, assert rst_i after 10 cycles -> no done_o. After release, a new start with A_i=2, B_i=9 -> result_o=18.
- Random regression: 20+ back-to-back random 32-bit operand pairs, next start issued one cycle after done_o -> result_o equals A_i*B_i, computed 64-bit wide, on every done_o.
